onchip_mem_arbiter: RTL and testbench
=====================================

# onchip_mem_arbiter

Two-master arbiter that shares the single-port 1024×32 on-chip RAM (byte-enabled, registered address, unregistered output) between the Nios II data master (port 0) and the PCM sample DMA (port 1). It sits between both Avalon-MM masters and the RAM's s1 slave. It grants one access per cycle using round-robin arbitration, stalls the losing master with waitrequest, and returns read data with fixed one-cycle latency and a readdatavalid strobe.

## Interface
- ADDR_W, 10, word address width (1024 words)
- DATA_W, 32, data width; byteenable width is DATA_W/8
- MAX_LOCK, 16, max consecutive locked grants (used only with the lock feature)

- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- mN_address  in  ADDR_W  word address, N = 0, 1
- mN_byteenable  in  DATA_W/8  byte lanes for write
- mN_read / mN_write  in  1  transfer request
- mN_writedata  in  DATA_W  write data
- mN_lock  in  1  hold grant after this transfer (lock feature only)
- mN_waitrequest  out  1  high = request not accepted this cycle
- mN_readdata  out  DATA_W  read data, valid with readdatavalid
- mN_readdatavalid  out  1  one-cycle read-return strobe
- mem_address  out  ADDR_W  to RAM
- mem_byteenable  out  DATA_W/8  to RAM
- mem_chipselect  out  1  to RAM
- mem_write  out  1  to RAM
- mem_writedata  out  DATA_W  to RAM
- mem_readdata  in  DATA_W  from RAM q

## Operation
- reqN = mN_read | mN_write. Grant is combinational from reqN, last_grant, and lock state.
- Round robin:
  - Only one master requesting: that master is granted.
  - Both requesting: the master != last_grant is granted.
  - last_grant updates to the granted master on every accepted transfer.
- mN_waitrequest = reqN & ~grantN.
  - A transfer is accepted in the cycle its master sees waitrequest low.
  - Masters hold address, data, and request until accepted.
- RAM mux:
  - mem_* driven from the granted master.
  - mem_chipselect = grant0 | grant1.
  - mem_write = granted master's write.
  - With no grant: mem_chipselect = 0 and mem_write = 0; address, byteenable, and writedata hold port 0 values.
- Read return:
  - An accepted read sets rd_pending and stores rd_owner.
  - Next cycle: m{rd_owner}_readdatavalid = 1.
  - Both mN_readdata are wired to mem_readdata.
- read and write both high on one master: treated as a write. No readdatavalid is generated.
- Registered state and reset values:
  - last_grant = 1, so port 0 wins the first tie.
  - rd_pending = 0, rd_owner = 0, locked = 0, lock_cnt = 0.
- While reset_n is low:
  - No grants.
  - mN_waitrequest = reqN.
  - mem_chipselect = 0, mem_write = 0, both readdatavalid = 0.
- Reset mid-operation: a pending read is dropped and its readdatavalid is never issued.

## Timing
- Accept to RAM: same cycle, combinational mux.
- Read: accepted at cycle T → readdatavalid and readdata at T+1.
- Throughput: one transfer per cycle. Reads are fully pipelined, so back-to-back reads from either master return in order at T+1, T+2, …
- Write then read to the same address in consecutive cycles: the read returns the new data.
- Both masters continuously requesting: grants alternate 0,1,0,1… Each master waits at most 1 cycle (lock feature off).
- The arbiter adds no combinational path from mem_readdata into the grant logic.

## Configuration
- MEMARB_LOCK_EN defined, lock feature enabled:
  - An accepted transfer with mN_lock = 1 sets locked = 1 and owner = N, and increments lock_cnt.
  - While locked, only master N can be granted; the other master is stalled even if N is idle.
  - The lock releases on an accepted transfer from N with mN_lock = 0, or when lock_cnt reaches MAX_LOCK.
  - A forced release clears lock_cnt and sets last_grant = N, so a requesting other master wins the next cycle.
- MEMARB_LOCK_EN undefined: mN_lock is ignored, the lock registers and counter are removed, and arbitration is pure round robin.

## Test plan
- Reset release, both masters idle → all waitrequest = 0, mem_chipselect = 0, no readdatavalid. First simultaneous read (m0 @0x010, m1 @0x020) → m0 granted first, m1 granted next cycle.
- m0 writes 0xDEADBEEF @0x3FF with byteenable 0xF, then reads @0x3FF in the next cycle → m0_readdatavalid at T+1 with 0xDEADBEEF; m1_readdatavalid stays 0.
- Byte-lane write: m1 writes 0x000000AA, byteenable 0x1, over 0x11223344 @0x005 → readback 0x112233AA.
- Both masters stream 8 reads each → strict alternation, 16 readdatavalid pulses in grant order, each master's waitrequest high for no more than 1 consecutive cycle.
- reset_n asserted in the cycle after an accepted m1 read → no m1_readdatavalid; after release, last_grant = 1.
- With MEMARB_LOCK_EN, m0 holds lock high for 20 transfers while m1 requests → m0 gets 16 consecutive grants, then m1 is granted; without the macro, grants alternate.

Source files
------------

// File: rtl/onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : onchip_mem_arbiter
// Purpose  : Two-master round-robin arbiter in front of a single-port
//            1024x32 on-chip RAM (registered address, unregistered q).
//            Port 0 is the Nios II data master, port 1 the PCM sample DMA.
//            One transfer is granted per cycle; the losing master is held
//            off with waitrequest. Reads return one cycle after acceptance
//            with a per-master readdatavalid strobe.
// Optional : define MEMARB_LOCK_EN to enable the mN_lock grant-hold feature
//            (bounded by MAX_LOCK consecutive locked grants).
// Ports    : clk, reset_n (async, active-low)
//            m0_* / m1_* : Avalon-MM slave side for each master
//                          (address, byteenable, read, write, writedata,
//                           lock in; waitrequest, readdata,
//                           readdatavalid out)
//            mem_*       : RAM s1 side (address, byteenable, chipselect,
//                          write, writedata out; readdata in)
// Revision : 1.0 - initial release
// ============================================================================
module onchip_mem_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 16
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic                m0_lock,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic                m1_lock,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    input  logic [DATA_W-1:0]   mem_readdata
);

    logic w_req0;
    logic w_req1;
    logic w_grant0;
    logic w_grant1;
    logic w_accept;
    logic w_acc_read;
    // Lock holds: w_hold0 means only master 0 may be granted, and vice versa.
    logic w_hold0;
    logic w_hold1;

    // r_last_grant: 0/1 = master served most recently (1 out of reset so
    // master 0 wins the first tie).
    logic r_last_grant;
    logic r_rd_pending;
    logic r_rd_owner;

    assign w_req0 = m0_read | m0_write;
    assign w_req1 = m1_read | m1_write;

`ifdef MEMARB_LOCK_EN
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    logic             r_locked;
    logic             r_lock_owner;
    logic [CNT_W-1:0] r_lock_cnt;
    logic             w_acc_lock;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_hold0    = r_locked & ~r_lock_owner;
    assign w_hold1    = r_locked &  r_lock_owner;
    assign w_acc_lock = (w_grant0 & m0_lock) | (w_grant1 & m1_lock);
    assign w_cnt_inc  = r_lock_cnt + CNT_W'(1);

    // Only the lock owner can be granted while locked, so any accepted
    // transfer without lock is the owner releasing. Reaching MAX_LOCK forces
    // a release; last_grant already points at the owner, so a waiting other
    // master wins the following tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_locked     <= 1'b0;
            r_lock_owner <= 1'b0;
            r_lock_cnt   <= '0;
        end else if (w_accept) begin
            if (w_acc_lock) begin
                if (w_cnt_inc == CNT_W'(MAX_LOCK)) begin
                    r_locked   <= 1'b0;
                    r_lock_cnt <= '0;
                end else begin
                    r_locked     <= 1'b1;
                    r_lock_owner <= w_grant1;
                    r_lock_cnt   <= w_cnt_inc;
                end
            end else begin
                r_locked   <= 1'b0;
                r_lock_cnt <= '0;
            end
        end
    end
`else
    logic w_unused_lock;

    assign w_hold0       = 1'b0;
    assign w_hold1       = 1'b0;
    assign w_unused_lock = m0_lock | m1_lock | (MAX_LOCK == 0);
`endif

    // Grant depends only on requests and registered state; mem_readdata
    // never feeds back into it. Gated by reset_n so nothing is granted while
    // reset is held.
    assign w_grant0 = reset_n & w_req0 & ~w_hold1 &
                      (~w_req1 | w_hold0 |  r_last_grant);
    assign w_grant1 = reset_n & w_req1 & ~w_hold0 &
                      (~w_req0 | w_hold1 | ~r_last_grant);

    assign w_accept   = w_grant0 | w_grant1;
    // read+write together is a write: no read return is scheduled.
    assign w_acc_read = (w_grant0 & m0_read & ~m0_write) |
                        (w_grant1 & m1_read & ~m1_write);

    assign m0_waitrequest = w_req0 & ~w_grant0;
    assign m1_waitrequest = w_req1 & ~w_grant1;

    // Port 0 is the default mux leg when nothing is granted.
    assign mem_address    = w_grant1 ? m1_address    : m0_address;
    assign mem_byteenable = w_grant1 ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = w_grant1 ? m1_writedata  : m0_writedata;
    assign mem_chipselect = w_accept;
    assign mem_write      = (w_grant0 & m0_write) | (w_grant1 & m1_write);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= 1'b1;
            r_rd_pending <= 1'b0;
            r_rd_owner   <= 1'b0;
        end else begin
            r_rd_pending <= w_acc_read;
            if (w_acc_read) begin
                r_rd_owner <= w_grant1;
            end
            if (w_accept) begin
                r_last_grant <= w_grant1;
            end
        end
    end

    // RAM q is valid the cycle after the address was registered, which is
    // exactly when the pending strobe is high.
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = r_rd_pending & ~r_rd_owner;
    assign m1_readdatavalid = r_rd_pending &  r_rd_owner;

endmodule
`default_nettype wire

// File: tb/tb_onchip_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_onchip_mem_arbiter
// Purpose  : Self-checking bench for onchip_mem_arbiter. Contains a RAM
//            model on the mem_* side and a transaction-level reference model
//            (whose-turn / lock holder / shadow memory) that predicts grants,
//            RAM controls and read returns every cycle. Honours
//            MEMARB_LOCK_EN the same way the design does.
// Revision : 1.0 - initial release
// ============================================================================
module tb_onchip_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [9:0]  addr [2];
    logic [3:0]  be   [2];
    logic        rd   [2];
    logic        wr   [2];
    logic        lk   [2];
    logic [31:0] wd   [2];

    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [9:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write;
    logic [31:0] mem_writedata, mem_readdata;

    onchip_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_LOCK(16)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .m0_address       (addr[0]),
        .m0_byteenable    (be[0]),
        .m0_read          (rd[0]),
        .m0_write         (wr[0]),
        .m0_writedata     (wd[0]),
        .m0_lock          (lk[0]),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (addr[1]),
        .m1_byteenable    (be[1]),
        .m1_read          (rd[1]),
        .m1_write         (wr[1]),
        .m1_writedata     (wd[1]),
        .m1_lock          (lk[1]),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_readdata     (mem_readdata)
    );

    function automatic logic [31:0] init_val(input logic [9:0] a);
        return ({22'h0, a} * 32'h9E3779B1) ^ 32'hA5A50F0F;
    endfunction

    // RAM: registered address, unregistered q, byte-enabled write.
    logic [31:0] ram [1024];
    logic [9:0]  ram_addr_q;
    bit          ram_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 1024; i++) ram[i] <= init_val(10'(i));
            ram_ready <= 1'b1;
        end else if (mem_chipselect) begin
            ram_addr_q <= mem_address;
            if (mem_write)
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
    end
    assign mem_readdata = ram[ram_addr_q];

    // ---------------- reference model state ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_mem [1024];
    int          turn;           // master that wins a tie
    int          lk_owner;       // -1 = unlocked
    int          lk_cnt;
    bit          exp_rv [2];
    logic [31:0] exp_data;
    bit          mod_acc [2];
    bit          dut_acc [2];
    int          run [2];
    int          max_run [2];
    int          rdv_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        turn = 0; lk_owner = -1; lk_cnt = 0;
        exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
    endtask

    task automatic set_idle(input int m);
        rd[m] = 1'b0; wr[m] = 1'b0; lk[m] = 1'b0;
        addr[m] = '0; be[m] = '0; wd[m] = '0;
    endtask

    task automatic set_rd(input int m, input logic [9:0] a);
        set_idle(m); rd[m] = 1'b1; addr[m] = a; be[m] = 4'hF;
    endtask

    task automatic set_wr(input int m, input logic [9:0] a, input logic [31:0] d, input logic [3:0] e);
        set_idle(m); wr[m] = 1'b1; addr[m] = a; wd[m] = d; be[m] = e;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
    endtask

    // One bus cycle: sample at negedge, compare against the model, advance
    // the model, return at posedge+1 ready for new stimulus.
    task automatic step(input string tag);
        int g;
        bit r [2];
        @(negedge clk);
        r[0] = rd[0] | wr[0];
        r[1] = rd[1] | wr[1];

        check({tag, " rdv0"}, {31'b0, m0_readdatavalid}, {31'b0, exp_rv[0]});
        check({tag, " rdv1"}, {31'b0, m1_readdatavalid}, {31'b0, exp_rv[1]});
        if (exp_rv[0]) check({tag, " rdata0"}, m0_readdata, exp_data);
        if (exp_rv[1]) check({tag, " rdata1"}, m1_readdata, exp_data);
        rdv_cnt += int'(m0_readdatavalid) + int'(m1_readdatavalid);

        g = -1;
        if (reset_n) begin
            if (lk_owner >= 0) begin
                if (r[lk_owner]) g = lk_owner;
            end else if (r[0] && r[1]) g = turn;
            else if (r[0]) g = 0;
            else if (r[1]) g = 1;
        end

        check({tag, " wait0"}, {31'b0, m0_waitrequest}, {31'b0, r[0] && g != 0});
        check({tag, " wait1"}, {31'b0, m1_waitrequest}, {31'b0, r[1] && g != 1});
        check({tag, " cs"}, {31'b0, mem_chipselect}, {31'b0, g >= 0});
        if (g >= 0) begin
            check({tag, " mwr"}, {31'b0, mem_write}, {31'b0, wr[g]});
            check({tag, " maddr"}, {22'b0, mem_address}, {22'b0, addr[g]});
        end else begin
            check({tag, " mwr"}, {31'b0, mem_write}, 32'd0);
        end

        dut_acc[0] = r[0] & ~m0_waitrequest;
        dut_acc[1] = r[1] & ~m1_waitrequest;
        run[0] = m0_waitrequest ? run[0] + 1 : 0;
        run[1] = m1_waitrequest ? run[1] + 1 : 0;
        for (int m = 0; m < 2; m++) if (run[m] > max_run[m]) max_run[m] = run[m];

        exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
        mod_acc[0] = (g == 0); mod_acc[1] = (g == 1);
        if (!reset_n) begin
            model_reset();
        end else if (g >= 0) begin
            if (wr[g]) begin
                for (int b = 0; b < 4; b++)
                    if (be[g][b]) model_mem[addr[g]][8*b +: 8] = wd[g][8*b +: 8];
            end else begin
                exp_rv[g] = 1'b1;
                exp_data  = model_mem[addr[g]];
            end
            turn = 1 - g;
`ifdef MEMARB_LOCK_EN
            if (lk[g]) begin
                lk_cnt++;
                if (lk_cnt == 16) begin lk_owner = -1; lk_cnt = 0; end
                else lk_owner = g;
            end else begin
                lk_owner = -1; lk_cnt = 0;
            end
`endif
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n [2];
        int c0, cnt0, run0;
        bit seen1;

        for (int i = 0; i < 1024; i++) model_mem[i] = init_val(10'(i));
        run[0] = 0; run[1] = 0; max_run[0] = 0; max_run[1] = 0;
        set_idle(0); set_idle(1);
        do_reset();
        set_rd(0, 10'h001);               // waitrequest must follow request in reset
        @(posedge clk); #1;
        step("in_reset");
        step("in_reset");
        reset_n = 1'b1;
        set_idle(0);
        step("idle");

        // First tie: master 0 first, master 1 next cycle.
        set_rd(0, 10'h010); set_rd(1, 10'h020);
        step("tie1");
        check("tie1 m0_acc", {31'b0, dut_acc[0]}, 32'd1);
        check("tie1 m1_acc", {31'b0, dut_acc[1]}, 32'd0);
        set_idle(0);
        step("tie2");
        check("tie2 m1_acc", {31'b0, dut_acc[1]}, 32'd1);
        set_idle(1);
        step("idle");

        // Write then read the same address back to back.
        set_wr(0, 10'h3FF, 32'hDEADBEEF, 4'hF);
        step("wr3ff");
        set_rd(0, 10'h3FF);
        step("rd3ff");
        set_idle(0);
        check("rd3ff rdv0", {31'b0, m0_readdatavalid}, 32'd1);
        check("rd3ff data", m0_readdata, 32'hDEADBEEF);
        check("rd3ff rdv1", {31'b0, m1_readdatavalid}, 32'd0);
        step("idle");

        // Byte-lane merge.
        set_wr(1, 10'h005, 32'h11223344, 4'hF);
        step("bl_full");
        set_wr(1, 10'h005, 32'h000000AA, 4'h1);
        step("bl_lane");
        set_rd(1, 10'h005);
        step("bl_rd");
        set_idle(1);
        check("bl_rd data", m1_readdata, 32'h112233AA);
        check("bl_rd rdv1", {31'b0, m1_readdatavalid}, 32'd1);
        step("idle");

        // Both masters stream 8 reads.
        n[0] = 0; n[1] = 0; max_run[0] = 0; max_run[1] = 0;
        c0 = rdv_cnt;
        set_rd(0, 10'h040); set_rd(1, 10'h080);
        for (int k = 0; k < 40 && (n[0] < 8 || n[1] < 8); k++) begin
            step("stream");
            for (int m = 0; m < 2; m++)
                if (mod_acc[m]) begin
                    n[m]++;
                    if (n[m] < 8) set_rd(m, 10'((m == 0 ? 'h040 : 'h080) + n[m]));
                    else set_idle(m);
                end
        end
        step("stream_drain");
        check("stream done", n[0] * 8 + n[1], 32'd72);
        check("stream rdv_pulses", rdv_cnt - c0, 32'd16);
        check("stream maxwait0", {31'b0, max_run[0] <= 1}, 32'd1);
        check("stream maxwait1", {31'b0, max_run[1] <= 1}, 32'd1);

        // Reset one cycle after an accepted m1 read.
        set_rd(1, 10'h007);
        step("rst_rd");
        set_idle(1);
        do_reset();
        set_rd(0, 10'h008); set_rd(1, 10'h009);
        step("rst_hold");
        reset_n = 1'b1;
        step("rst_tie");
        check("rst_tie m0_acc", {31'b0, dut_acc[0]}, 32'd1);
        check("rst_tie m1_acc", {31'b0, dut_acc[1]}, 32'd0);
        set_idle(0);
        step("rst_tie2");
        set_idle(1);
        step("idle");

        // Lock: m0 keeps lock high for 20 transfers while m1 requests.
        do_reset();
        step("lk_rst");
        reset_n = 1'b1;
        n[0] = 0; cnt0 = 0; run0 = -1; seen1 = 1'b0;
        set_rd(0, 10'h100); lk[0] = 1'b1;
        set_rd(1, 10'h200);
        for (int k = 0; k < 60 && (n[0] < 20 || rd[1]); k++) begin
            step("lock");
            if (dut_acc[1] && !seen1) begin seen1 = 1'b1; run0 = cnt0; end
            if (dut_acc[0] && !seen1) cnt0++;
            if (mod_acc[0]) begin
                n[0]++;
                if (n[0] < 20) begin set_rd(0, 10'(10'h100 + n[0])); lk[0] = 1'b1; end
                else set_idle(0);
            end
            if (mod_acc[1]) set_idle(1);
        end
        step("lock_drain");
`ifdef MEMARB_LOCK_EN
        check("lock run_before_m1", run0, 32'd16);
`else
        check("lock run_before_m1", run0, 32'd1);
`endif

        // Randomised traffic on a small address window.
        do_reset();
        set_idle(0); set_idle(1);
        step("rnd_rst");
        reset_n = 1'b1;
        for (int k = 0; k < 400; k++) begin
            for (int m = 0; m < 2; m++)
                if (!(rd[m] | wr[m])) begin
                    int op;
                    op = int'($urandom_range(0, 7));
                    set_idle(m);
                    if (op >= 2) begin
                        addr[m] = 10'($urandom_range(0, 15));
                        wd[m]   = $urandom;
                        be[m]   = 4'($urandom_range(0, 15));
                        rd[m]   = (op <= 4) || (op == 7);
                        wr[m]   = (op >= 5);
                        lk[m]   = ($urandom_range(0, 3) == 0);
                    end
                end
            step("rand");
            for (int m = 0; m < 2; m++) if (mod_acc[m]) set_idle(m);
        end
        set_idle(0); set_idle(1);
        step("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
